accel_digit_formatter: RTL and testbench

- Producer side of the seven-segment path: turns signed accelerometer axis readings into per-digit 4-bit codes for the existing hex-to-segment decoder instances (codes 0-9 digits, 10/11/12 = X/Y/Z letters, 15 = blank).
- Cycles the shown axis X→Y→Z on a fixed dwell timer.
- Converts each magnitude to BCD with a sequential double-dabble engine.
- Sits between the accelerometer reader and six decoder instances (HEX5..HEX0).

---
 rtl/accel_digit_formatter_pkg.sv | 49 ++++
 rtl/accel_digit_formatter_bin2bcd_seq.sv | 66 ++++++
 rtl/accel_digit_formatter.sv | 212 +++++++++++++++++++++
 tb/tb_accel_digit_formatter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_digit_formatter_pkg.sv
// Shared definitions for the accelerometer seven-segment formatter: digit codes,
// axis encodings, controller states and the BCD helpers.
package accel_digit_formatter_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [3:0] CODE_X     = 4'd10;
   localparam logic [3:0] CODE_Y     = 4'd11;
   localparam logic [3:0] CODE_Z     = 4'd12;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   localparam logic [1:0] AXIS_X = 2'd0;
   localparam logic [1:0] AXIS_Y = 2'd1;
   localparam logic [1:0] AXIS_Z = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } fmt_state_t;

   function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

   // Digits 3..1 turn blank while they and every higher digit are zero.
   function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
      logic [15:0] res;
      logic        lead;
      res  = bcd;
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
            res[i*4 +: 4] = CODE_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/accel_digit_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock for
// DATA_W clocks after start; done pulses once the BCD result is final.
module bin2bcd_seq
   import accel_digit_formatter_pkg::*;
#(
   parameter int DATA_W = 12
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bin,
   output logic              done,
   output logic [15:0]       bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_r;
   logic [15:0]       bcd_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              active_r;
   logic              done_r;
   logic [15:0]       adj_s;

   // add-3 correction on every nibble ahead of the shift
   always_comb begin
      adj_s = bcd_r;
      for (int i = 0; i < 4; i++) begin
         adj_s[i*4 +: 4] = dabble_adjust(bcd_r[i*4 +: 4]);
      end
   end

   // conversion sequencer and shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_r    <= '0;
         bcd_r    <= 16'd0;
         cnt_r    <= '0;
         active_r <= 1'b0;
         done_r   <= 1'b0;
      end else if (start) begin
         bin_r    <= bin;
         bcd_r    <= 16'd0;
         cnt_r    <= '0;
         active_r <= 1'b1;
         done_r   <= 1'b0;
      end else if (active_r) begin
         bcd_r <= {adj_s[14:0], bin_r[DATA_W-1]};
         bin_r <= bin_r << 1;
         cnt_r <= cnt_r + CNT_W'(1);
         if (cnt_r == CNT_W'(DATA_W - 1)) begin
            active_r <= 1'b0;
            done_r   <= 1'b1;
         end else begin
            active_r <= 1'b1;
            done_r   <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done = done_r;
   assign bcd  = bcd_r;

endmodule

// File: rtl/accel_digit_formatter.sv
// Turns captured signed X/Y/Z samples into six seven-segment digit codes,
// rotating the shown axis on a dwell timer and converting via bin2bcd_seq.
module accel_digit_formatter
   import accel_digit_formatter_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int CLK_HZ   = 50000000,
   parameter int DWELL_MS = 1000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] x_data,
   input  logic [DATA_W-1:0] y_data,
   input  logic [DATA_W-1:0] z_data,
   input  logic              sample_valid,
   output logic [3:0]        dig5,
   output logic [3:0]        dig4,
   output logic [3:0]        dig3,
   output logic [3:0]        dig2,
   output logic [3:0]        dig1,
   output logic [3:0]        dig0,
   output logic              neg,
   output logic [1:0]        axis,
   output logic              busy
);

   localparam int DWELL_CYC = CLK_HZ / 1000 * DWELL_MS;
   localparam int DW_W      = $clog2(DWELL_CYC);
   localparam int SC_W      = $clog2(DATA_W + 1);

   fmt_state_t        state_r;
   fmt_state_t        state_nx_s;
   logic [DATA_W-1:0] x_cap_r;
   logic [DATA_W-1:0] y_cap_r;
   logic [DATA_W-1:0] z_cap_r;
   logic [DW_W-1:0]   dwell_cnt_r;
   logic [1:0]        axis_r;
   logic [1:0]        load_axis_r;
   logic              sign_r;
   logic              init_req_r;
   logic              pending_r;
   logic [SC_W-1:0]   shift_cnt_r;
   logic              busy_r;
   logic              neg_r;
   logic [3:0]        dig5_r;
   logic [15:0]       digs_r;
   logic [DATA_W-1:0] sel_s;
   logic [DATA_W-1:0] mag_s;
   logic              wrap_s;
   logic              req_s;
   logic              eng_done_s;
   logic [15:0]       eng_bcd_s;

   assign wrap_s = (dwell_cnt_r == DW_W'(DWELL_CYC - 1));
   assign req_s  = init_req_r | wrap_s | sample_valid;

   // sample capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_cap_r <= '0;
         y_cap_r <= '0;
         z_cap_r <= '0;
      end else if (sample_valid) begin
         x_cap_r <= x_data;
         y_cap_r <= y_data;
         z_cap_r <= z_data;
      end else begin
         x_cap_r <= x_cap_r;
         y_cap_r <= y_cap_r;
         z_cap_r <= z_cap_r;
      end
   end

   // dwell timer and axis rotation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_cnt_r <= '0;
         axis_r      <= AXIS_X;
      end else if (wrap_s) begin
         dwell_cnt_r <= '0;
         case (axis_r)
            AXIS_X:  axis_r <= AXIS_Y;
            AXIS_Y:  axis_r <= AXIS_Z;
            AXIS_Z:  axis_r <= AXIS_X;
            default: axis_r <= AXIS_X;
         endcase
      end else begin
         dwell_cnt_r <= dwell_cnt_r + DW_W'(1);
         axis_r      <= axis_r;
      end
   end

   // start-request bookkeeping: one-shot after reset plus a merged pending flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_req_r <= 1'b1;
         pending_r  <= 1'b0;
      end else begin
         init_req_r <= 1'b0;
         if (state_r == ST_IDLE) begin
            pending_r <= 1'b0;
         end else if (req_s) begin
            pending_r <= 1'b1;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

   // sample for the current axis and its magnitude; the most negative value
   // wraps to exactly 2^(DATA_W-1) as an unsigned number
   always_comb begin
      sel_s = x_cap_r;
      case (axis_r)
         AXIS_X:  sel_s = x_cap_r;
         AXIS_Y:  sel_s = y_cap_r;
         AXIS_Z:  sel_s = z_cap_r;
         default: sel_s = x_cap_r;
      endcase
      if (sel_s[DATA_W-1]) begin
         mag_s = ~sel_s + DATA_W'(1);
      end else begin
         mag_s = sel_s;
      end
   end

   // controller next state
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s || pending_r) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: state_nx_s = ST_SHIFT;
         ST_SHIFT: begin
            if (shift_cnt_r == SC_W'(DATA_W - 1)) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_SHIFT;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // controller state, LOAD-time context and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         shift_cnt_r <= '0;
         load_axis_r <= AXIS_X;
         sign_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
         if (state_r == ST_LOAD) begin
            shift_cnt_r <= '0;
            load_axis_r <= axis_r;
            sign_r      <= sel_s[DATA_W-1];
         end else if (state_r == ST_SHIFT) begin
            shift_cnt_r <= shift_cnt_r + SC_W'(1);
         end else begin
            shift_cnt_r <= shift_cnt_r;
         end
      end
   end

   bin2bcd_seq #(
      .DATA_W (DATA_W)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (state_r == ST_LOAD),
      .bin   (mag_s),
      .done  (eng_done_s),
      .bcd   (eng_bcd_s)
   );

   // display registers change only in DONE, all together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig5_r <= CODE_BLANK;
         digs_r <= {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};
         neg_r  <= 1'b0;
      end else if ((state_r == ST_DONE) && eng_done_s) begin
         dig5_r <= CODE_X + {2'b00, load_axis_r};
         digs_r <= blank_leading(eng_bcd_s);
         neg_r  <= sign_r;
      end else begin
         dig5_r <= dig5_r;
         digs_r <= digs_r;
         neg_r  <= neg_r;
      end
   end

   assign dig5 = dig5_r;
   assign dig4 = CODE_BLANK;
   assign dig3 = digs_r[15:12];
   assign dig2 = digs_r[11:8];
   assign dig1 = digs_r[7:4];
   assign dig0 = digs_r[3:0];
   assign neg  = neg_r;
   assign axis = axis_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_accel_digit_formatter.sv
// Directed bench for accel_digit_formatter with a 40-cycle dwell: vector table
// per axis plus reset, dwell rotation, pending-merge and coincidence sequences.
module tb_accel_digit_formatter;

   localparam int DATA_W = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] x_data = '0;
   logic [DATA_W-1:0] y_data = '0;
   logic [DATA_W-1:0] z_data = '0;
   logic              sample_valid = 1'b0;
   logic [3:0]        dig5, dig4, dig3, dig2, dig1, dig0;
   logic              neg;
   logic [1:0]        axis;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int conv_cnt = 0;
   int conv_base;
   logic busy_q = 1'b0;

   typedef struct {
      logic [1:0] ax;
      int         val;
      int         e5, e3, e2, e1, e0, en;
   } vec_t;

   vec_t vecs [10];

   accel_digit_formatter #(
      .DATA_W   (DATA_W),
      .CLK_HZ   (1000),
      .DWELL_MS (40)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .x_data       (x_data),
      .y_data       (y_data),
      .z_data       (z_data),
      .sample_valid (sample_valid),
      .dig5         (dig5),
      .dig4         (dig4),
      .dig3         (dig3),
      .dig2         (dig2),
      .dig1         (dig1),
      .dig0         (dig0),
      .neg          (neg),
      .axis         (axis),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // count conversions as rising edges of busy
   always @(negedge clk) begin
      if (busy && !busy_q) conv_cnt++;
      busy_q = busy;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_disp(input string name, input int e5, input int e3, input int e2,
                           input int e1, input int e0, input int en);
      chk({name, ".dig5"}, int'(dig5), e5);
      chk({name, ".dig4"}, int'(dig4), 15);
      chk({name, ".dig3"}, int'(dig3), e3);
      chk({name, ".dig2"}, int'(dig2), e2);
      chk({name, ".dig1"}, int'(dig1), e1);
      chk({name, ".dig0"}, int'(dig0), e0);
      chk({name, ".neg"},  int'(neg),  en);
   endtask

   // returns at the negedge right after an axis change
   task automatic wait_wrap();
      logic [1:0] a0;
      bit seen;
      a0 = axis;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (axis != a0) seen = 1'b1;
      end
      if (!seen) chk("dwell_wrap_timeout", 0, 1);
   endtask

   task automatic wait_axis(input logic [1:0] a);
      for (int k = 0; k < 4; k++) begin
         wait_wrap();
         if (axis == a) break;
      end
   endtask

   task automatic drive_axis(input logic [1:0] a, input int val);
      case (a)
         2'd0:    x_data = val[DATA_W-1:0];
         2'd1:    y_data = val[DATA_W-1:0];
         default: z_data = val[DATA_W-1:0];
      endcase
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{2'd0,  1234, 10,  1,  2,  3, 4, 0};
      vecs[1] = '{2'd0,    -5, 10, 15, 15, 15, 5, 1};
      vecs[2] = '{2'd0, -2048, 10,  2,  0,  4, 8, 1};
      vecs[3] = '{2'd1,   307, 11, 15,  3,  0, 7, 0};
      vecs[4] = '{2'd2,  -100, 12, 15,  1,  0, 0, 1};
      vecs[5] = '{2'd0,     0, 10, 15, 15, 15, 0, 0};
      vecs[6] = '{2'd1,  2047, 11,  2,  0,  4, 7, 0};
      vecs[7] = '{2'd2,     9, 12, 15, 15, 15, 9, 0};
      vecs[8] = '{2'd0,    -1, 10, 15, 15, 15, 1, 1};
      vecs[9] = '{2'd2,  1000, 12,  1,  0,  0, 0, 0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_disp("reset", 15, 15, 15, 15, 15, 0);
      chk("reset.axis", int'(axis), 0);
      chk("reset.busy", int'(busy), 0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_disp("after_reset", 10, 15, 15, 15, 0, 0);
      chk("after_reset.busy", int'(busy), 0);

      // reset asserted in the middle of SHIFT
      x_data = 12'hB2E;  // -1234
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_shift.busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk_disp("mid_shift_reset", 15, 15, 15, 15, 15, 0);
      chk("mid_shift_reset.busy", int'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_disp("mid_shift_recover", 10, 15, 15, 15, 0, 0);

      // table-driven conversions, each placed just after its axis comes up
      for (int v = 0; v < 10; v++) begin
         wait_axis(vecs[v].ax);
         repeat (16) @(posedge clk);
         #1;
         drive_axis(vecs[v].ax, vecs[v].val);
         sample_valid = 1'b1;
         @(posedge clk);
         #1 sample_valid = 1'b0;
         repeat (13) @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d.busy_t14", v), int'(busy), 1);
         @(posedge clk);
         @(negedge clk);
         chk_disp($sformatf("vec%0d", v), vecs[v].e5, vecs[v].e3, vecs[v].e2,
                  vecs[v].e1, vecs[v].e0, vecs[v].en);
         chk($sformatf("vec%0d.axis", v), int'(axis), int'(vecs[v].ax));
         chk($sformatf("vec%0d.busy_done", v), int'(busy), 0);
      end

      // dwell rotation shows previously captured samples
      wait_axis(2'd0);
      repeat (16) @(posedge clk);
      #1;
      y_data = 12'd307;
      z_data = 12'd0;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      wait_wrap();
      chk("dwell1.axis", int'(axis), 1);
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk_disp("dwell1", 11, 15, 3, 0, 7, 0);
      wait_wrap();
      chk("dwell2.axis", int'(axis), 2);
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk_disp("dwell2", 12, 15, 15, 15, 0, 0);
      wait_wrap();
      chk("dwell3.axis", int'(axis), 0);

      // sample_valid coincident with wrap into Y: one conversion of the new sample
      repeat (39) @(posedge clk);
      #1;
      y_data = 12'd42;
      sample_valid = 1'b1;
      conv_base = conv_cnt;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk_disp("coincide", 11, 15, 15, 4, 2, 0);
      chk("coincide.axis", int'(axis), 1);
      chk("coincide.conversions", conv_cnt - conv_base, 1);

      // request while busy merges into a single reconversion
      wait_axis(2'd2);
      repeat (39) @(posedge clk);
      #1;
      x_data = 12'd10;
      sample_valid = 1'b1;
      conv_base = conv_cnt;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      @(posedge clk);
      #1;
      x_data = 12'd999;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk_disp("pending.first", 10, 15, 15, 1, 0, 0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk_disp("pending.second", 10, 15, 9, 9, 9, 0);
      chk("pending.busy", int'(busy), 0);
      chk("pending.conversions", conv_cnt - conv_base, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
